// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the write-back arbiter slice.
package regfile_pkg;

    localparam logic [3:0]  REG_PC   = 4'd15;
    localparam int unsigned NUM_REGS = 16;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_ALU,
        GNT_LSU
    } grant_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on reserve, cleared on commit.
module reg_scoreboard
    import regfile_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                set_en,
    input  logic [3:0]          set_sel,
    input  logic [NUM_REGS-1:0] clr_mask,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] set_mask;

    always_comb begin
        set_mask = '0;
        if (set_en) set_mask[set_sel] = 1'b1;
    end

    // Set is applied after clear so a same-edge reserve survives the commit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) busy <= '0;
        else          busy <= (busy & ~clr_mask) | set_mask;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between ALU and LSU, diverts r15
// writes to the PC path, and tracks pending destinations for hazard checks.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 3
)
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [3:0]          alu_sel,
    input  logic [31:0]         alu_data,
    input  logic [3:0]          alu_flags,
    input  logic                alu_flags_we,
    input  logic                lsu_valid,
    output logic                lsu_ready,
    input  logic [3:0]          lsu_sel,
    input  logic [31:0]         lsu_data,
    input  logic                rsv_valid,
    input  logic [3:0]          rsv_sel,
    output logic [NUM_REGS-1:0] busy,
    output logic                rf_we,
    output logic [3:0]          rf_sel,
    output logic [31:0]         rf_data,
    output logic [3:0]          rf_flags,
    output logic                pc_wr_valid,
    output logic [31:0]         pc_wr_data
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0]    starve_cnt;
    logic                starve;
    logic [3:0]          flags_shadow;
    grant_e              grant;
    logic [3:0]          win_sel;
    logic [31:0]         win_data;
    logic                win_flags_upd;
    logic [NUM_REGS-1:0] clr_mask;

    assign starve    = (starve_cnt == CNT_W'(STARVE_MAX));
    assign alu_ready = !lsu_valid || starve;
    assign lsu_ready = !(alu_valid && starve);

    always_comb begin
        grant         = GNT_NONE;
        win_sel       = lsu_sel;
        win_data      = lsu_data;
        win_flags_upd = 1'b0;
        if (lsu_valid && lsu_ready) begin
            grant = GNT_LSU;
        end else if (alu_valid && alu_ready) begin
            grant         = GNT_ALU;
            win_sel       = alu_sel;
            win_data      = alu_data;
            win_flags_upd = alu_flags_we;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (alu_valid && grant == GNT_LSU) begin
            if (!starve) starve_cnt <= starve_cnt + CNT_W'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

    // r15 results bypass the regfile entirely, so neither rf_* nor the shadow move.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_we        <= 1'b0;
            rf_sel       <= '0;
            rf_data      <= '0;
            rf_flags     <= '0;
            flags_shadow <= '0;
            pc_wr_valid  <= 1'b0;
            pc_wr_data   <= '0;
        end else begin
            rf_we       <= 1'b0;
            pc_wr_valid <= 1'b0;
            if (grant != GNT_NONE) begin
                if (win_sel == REG_PC) begin
                    pc_wr_valid <= 1'b1;
                    pc_wr_data  <= win_data;
                end else begin
                    rf_we   <= 1'b1;
                    rf_sel  <= win_sel;
                    rf_data <= win_data;
                    if (win_flags_upd) begin
                        rf_flags     <= alu_flags;
                        flags_shadow <= alu_flags;
                    end else begin
                        rf_flags <= flags_shadow;
                    end
                end
            end
        end
    end

    always_comb begin
        clr_mask = '0;
        if (rf_we)       clr_mask[rf_sel] = 1'b1;
        if (pc_wr_valid) clr_mask[REG_PC] = 1'b1;
    end

    reg_scoreboard u_scoreboard (
        .clock    (clock),
        .reset_n  (reset_n),
        .set_en   (rsv_valid),
        .set_sel  (rsv_sel),
        .clr_mask (clr_mask),
        .busy     (busy)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int unsigned SM = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        alu_valid, alu_ready, alu_flags_we;
    logic [3:0]  alu_sel, alu_flags;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [3:0]  lsu_sel;
    logic [31:0] lsu_data;
    logic        rsv_valid;
    logic [3:0]  rsv_sel;
    logic [15:0] busy;
    logic        rf_we, pc_wr_valid;
    logic [3:0]  rf_sel, rf_flags;
    logic [31:0] rf_data, pc_wr_data;

    int errors = 0;
    int checks = 0;
    logic [3:0] f_nc, f_zv;

    regfile_wb_arbiter #(.STARVE_MAX(SM)) dut (
        .clock(clock), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_sel(alu_sel),
        .alu_data(alu_data), .alu_flags(alu_flags), .alu_flags_we(alu_flags_we),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_sel(lsu_sel),
        .lsu_data(lsu_data), .rsv_valid(rsv_valid), .rsv_sel(rsv_sel),
        .busy(busy), .rf_we(rf_we), .rf_sel(rf_sel), .rf_data(rf_data),
        .rf_flags(rf_flags), .pc_wr_valid(pc_wr_valid), .pc_wr_data(pc_wr_data)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_sel = '0; alu_data = '0; alu_flags = '0; alu_flags_we = 0;
        lsu_valid = 0; lsu_sel = '0; lsu_data = '0;
        rsv_valid = 0; rsv_sel = '0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle_inputs();
        tick(); tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%0b want=0", rf_we); end
        checks++; if (busy !== 16'h0) begin errors++; $display("FAIL reset_busy got=%h want=0000", busy); end
        checks++; if (pc_wr_valid !== 1'b0) begin errors++; $display("FAIL reset_pc_valid got=%0b want=0", pc_wr_valid); end
        checks++; if (rf_flags !== 4'h0) begin errors++; $display("FAIL reset_flags got=%b want=0000", rf_flags); end
        reset_n = 1;
        tick();
    endtask

    task automatic test_alu_only();
        alu_valid = 1; alu_sel = 4'd3; alu_data = 32'hDEAD_BEEF; alu_flags = f_nc; alu_flags_we = 1;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_only_ready got=%0b want=1", alu_ready); end
        tick();
        alu_valid = 0;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL alu_only_we got=%0b want=1", rf_we); end
        checks++; if (rf_sel !== 4'd3) begin errors++; $display("FAIL alu_only_sel got=%0d want=3", rf_sel); end
        checks++; if (rf_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_only_data got=%h want=deadbeef", rf_data); end
        checks++; if (rf_flags !== 4'b1010) begin errors++; $display("FAIL alu_only_flags got=%b want=1010", rf_flags); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL alu_only_pulse got=%0b want=0", rf_we); end
        checks++; if (rf_sel !== 4'd3 || rf_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL idle_hold got=%0d/%h want=3/deadbeef", rf_sel, rf_data);
        end
    endtask

    task automatic test_lsu_shadow();
        lsu_valid = 1; lsu_sel = 4'd5; lsu_data = 32'h0000_5555;
        tick();
        lsu_valid = 0;
        checks++; if (rf_we !== 1'b1 || rf_sel !== 4'd5) begin errors++; $display("FAIL lsu_write got=%0b/%0d want=1/5", rf_we, rf_sel); end
        checks++; if (rf_flags !== 4'b1010) begin errors++; $display("FAIL lsu_shadow got=%b want=1010", rf_flags); end
        tick();
    endtask

    task automatic test_starvation();
        bit want_alu;
        alu_valid = 1; alu_sel = 4'd1; alu_data = 32'hA1; alu_flags = 4'hF; alu_flags_we = 0;
        lsu_valid = 1; lsu_sel = 4'd2; lsu_data = 32'hB2;
        #1;
        for (int i = 0; i < 8; i++) begin
            want_alu = ((i % 4) == 3);
            checks++; if (alu_ready !== want_alu || lsu_ready !== !want_alu) begin
                errors++; $display("FAIL starve_ready[%0d] got=%0b%0b want=%0b%0b", i, alu_ready, lsu_ready, want_alu, !want_alu);
            end
            tick();
            checks++; if (rf_we !== 1'b1 || rf_sel !== (want_alu ? 4'd1 : 4'd2) || rf_flags !== 4'b1010) begin
                errors++; $display("FAIL starve_grant[%0d] got=%0b/%0d/%b want=1/%0d/1010", i, rf_we, rf_sel, rf_flags, want_alu ? 1 : 2);
            end
        end
        alu_valid = 0; lsu_valid = 0;
        tick();
    endtask

    task automatic test_r15();
        rsv_valid = 1; rsv_sel = REG_PC;
        tick();
        rsv_valid = 0;
        checks++; if (busy[15] !== 1'b1) begin errors++; $display("FAIL r15_reserve got=%0b want=1", busy[15]); end
        alu_valid = 1; alu_sel = REG_PC; alu_data = 32'h100; alu_flags = f_zv; alu_flags_we = 1;
        tick();
        alu_valid = 0;
        checks++; if (pc_wr_valid !== 1'b1 || pc_wr_data !== 32'h100) begin
            errors++; $display("FAIL r15_pc got=%0b/%h want=1/00000100", pc_wr_valid, pc_wr_data);
        end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r15_rf_we got=%0b want=0", rf_we); end
        tick();
        checks++; if (pc_wr_valid !== 1'b0 || busy[15] !== 1'b0) begin
            errors++; $display("FAIL r15_clear got=%0b/%0b want=0/0", pc_wr_valid, busy[15]);
        end
        lsu_valid = 1; lsu_sel = 4'd4; lsu_data = 32'h44;
        tick();
        lsu_valid = 0;
        checks++; if (rf_flags !== 4'b1010) begin errors++; $display("FAIL r15_shadow got=%b want=1010", rf_flags); end
        tick();
    endtask

    task automatic test_scoreboard_collide();
        rsv_valid = 1; rsv_sel = 4'd7;
        alu_valid = 1; alu_sel = 4'd7; alu_data = 32'h77; alu_flags_we = 0;
        tick();
        rsv_valid = 0; alu_valid = 0;
        checks++; if (busy[7] !== 1'b1 || rf_we !== 1'b1) begin errors++; $display("FAIL collide_pre got=%0b/%0b want=1/1", busy[7], rf_we); end
        rsv_valid = 1; rsv_sel = 4'd7;
        tick();
        rsv_valid = 0;
        checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL collide_set_wins got=%0b want=1", busy[7]); end
        tick();
        checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL collide_hold got=%0b want=1", busy[7]); end
    endtask

    task automatic test_reserve_commit();
        rsv_valid = 1; rsv_sel = 4'd2;
        tick();
        rsv_valid = 0;
        checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL rc_set got=%0b want=1", busy[2]); end
        lsu_valid = 1; lsu_sel = 4'd2; lsu_data = 32'h22;
        tick();
        lsu_valid = 0;
        checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL rc_before_commit got=%0b want=1", busy[2]); end
        tick();
        checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL rc_cleared got=%0b want=0", busy[2]); end
    endtask

    task automatic test_async_reset();
        rsv_valid = 1; rsv_sel = 4'd9;
        alu_valid = 1; alu_sel = 4'd9; alu_data = 32'h99; alu_flags = 4'hF; alu_flags_we = 1;
        tick();
        idle_inputs();
        #2 reset_n = 0;
        #1;
        checks++; if (rf_we !== 1'b0 || busy !== 16'h0 || rf_flags !== 4'h0) begin
            errors++; $display("FAIL async_reset got=%0b/%h/%b want=0/0000/0000", rf_we, busy, rf_flags);
        end
        @(posedge clock); #1 reset_n = 1;
        lsu_valid = 1; lsu_sel = 4'd1; lsu_data = 32'h11;
        tick();
        lsu_valid = 0;
        checks++; if (rf_flags !== 4'h0) begin errors++; $display("FAIL reset_shadow got=%b want=0000", rf_flags); end
        tick();
    endtask

    task automatic test_random();
        int unsigned denials;
        logic [15:0] m_busy;
        logic m_we, m_pc_v;
        logic [3:0] m_sel, m_flags, m_shadow, s;
        logic [31:0] m_data, m_pc_d, d;
        bit starve, ear, elr, a_acc, l_acc, a_hold, l_hold;
        idle_inputs();
        reset_n = 0;
        #1;
        @(posedge clock); #1 reset_n = 1;
        denials = 0; m_busy = '0; m_we = 0; m_pc_v = 0;
        m_sel = '0; m_flags = '0; m_shadow = '0; m_data = '0; m_pc_d = '0;
        a_hold = 0; l_hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (!a_hold) begin
                alu_valid = ($urandom_range(0, 9) < 7); alu_sel = 4'($urandom_range(0, 15));
                alu_data = $urandom; alu_flags = 4'($urandom_range(0, 15)); alu_flags_we = 1'($urandom_range(0, 1));
            end
            if (!l_hold) begin
                lsu_valid = ($urandom_range(0, 9) < 6); lsu_sel = 4'($urandom_range(0, 15)); lsu_data = $urandom;
            end
            rsv_valid = ($urandom_range(0, 3) == 0); rsv_sel = 4'($urandom_range(0, 15));
            #1;
            starve = (denials == SM);
            ear = !lsu_valid || starve;
            elr = !(alu_valid && starve);
            checks++; if (alu_ready !== ear || lsu_ready !== elr) begin
                errors++; $display("FAIL rnd_ready[%0d] got=%0b%0b want=%0b%0b", i, alu_ready, lsu_ready, ear, elr);
            end
            a_acc = alu_valid && ear;
            l_acc = lsu_valid && elr;
            if (m_we) m_busy[m_sel] = 1'b0;
            if (m_pc_v) m_busy[15] = 1'b0;
            if (rsv_valid) m_busy[rsv_sel] = 1'b1;
            if (alu_valid && l_acc) denials = (denials < SM) ? denials + 1 : SM;
            else denials = 0;
            m_we = 0; m_pc_v = 0;
            if (a_acc || l_acc) begin
                s = a_acc ? alu_sel : lsu_sel;
                d = a_acc ? alu_data : lsu_data;
                if (s == 4'd15) begin
                    m_pc_v = 1; m_pc_d = d;
                end else begin
                    m_we = 1; m_sel = s; m_data = d;
                    if (a_acc && alu_flags_we) m_shadow = alu_flags;
                    m_flags = m_shadow;
                end
            end
            a_hold = alu_valid && !a_acc;
            l_hold = lsu_valid && !l_acc;
            tick();
            checks++; if (rf_we !== m_we || rf_sel !== m_sel || rf_data !== m_data || rf_flags !== m_flags) begin
                errors++; $display("FAIL rnd_rf[%0d] got=%0b/%0d/%h/%b want=%0b/%0d/%h/%b", i, rf_we, rf_sel, rf_data, rf_flags, m_we, m_sel, m_data, m_flags);
            end
            checks++; if (pc_wr_valid !== m_pc_v || pc_wr_data !== m_pc_d) begin
                errors++; $display("FAIL rnd_pc[%0d] got=%0b/%h want=%0b/%h", i, pc_wr_valid, pc_wr_data, m_pc_v, m_pc_d);
            end
            checks++; if (busy !== m_busy) begin
                errors++; $display("FAIL rnd_busy[%0d] got=%h want=%h", i, busy, m_busy);
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        f_nc = '0; f_nc[FLAG_N] = 1'b1; f_nc[FLAG_C] = 1'b1;
        f_zv = '0; f_zv[FLAG_Z] = 1'b1; f_zv[FLAG_V] = 1'b1;
        test_reset();
        test_alu_only();
        test_lsu_shadow();
        test_starvation();
        test_r15();
        test_scoreboard_collide();
        test_reserve_commit();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
